ex_muldiv_unit: RTL

- Parametrised iterative multiply/divide unit for the EX stage.
- Owns the architectural HI/LO registers and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Raises a stall request toward the pipeline stall controller while a long operation is in progress.
- Replaces the fixed 32-bit mul/div pair with one shared state machine of configurable width and bits-per-cycle, adding annul (flush) support and defined divide-by-zero results.

---
 rtl/ex_muldiv_unit_if.sv | 31 +++
 rtl/ex_muldiv_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit_if
// Purpose  : EX-stage request/result bundle for the iterative mul/div unit.
// Revision : 1.0
// ============================================================================
interface ex_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [3:0]       op_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             annul_i;
  logic             stallreq_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, src1_i, src2_i, annul_i,
    input  stallreq_o, busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, src1_i, src2_i, annul_i,
    output stallreq_o, busy_o, done_o, hi_o, lo_o
  );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Purpose  : Iterative HI/LO multiply/divide unit, STEP bits per cycle.
//            Optional multiply-accumulate ops enabled by `define MDU_ACC_EN.
// Revision : 1.0
// ============================================================================
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  wire logic       clk,
  input  wire logic       resetn,
  ex_muldiv_unit_if.slave mdu
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_ACC_EN
  localparam logic [3:0] OP_MADD  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
  localparam logic [3:0] OP_MSUBU = 4'd11;
`endif

  // Returns {is_multiply, is_divide, is_signed}.
  function automatic logic [2:0] f_dec(input logic [3:0] op);
    logic mul, div, sgn;
    mul = (op == OP_MULT) || (op == OP_MULTU);
    div = (op == OP_DIV)  || (op == OP_DIVU);
    sgn = (op == OP_MULT) || (op == OP_DIV);
`ifdef MDU_ACC_EN
    if ((op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU))
      mul = 1'b1;
    if ((op == OP_MADD) || (op == OP_MSUB))
      sgn = 1'b1;
`endif
    return {mul, div, sgn};
  endfunction

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
`ifdef MDU_ACC_EN
  logic             r_acc;
  logic             r_sub;
`endif

  logic [2:0]       w_dec;
  logic             w_in_mul;
  logic             w_in_div;
  logic             w_in_long;
  logic             w_s1;
  logic             w_s2;
  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;

  assign w_dec     = f_dec(mdu.op_i);
  assign w_in_mul  = w_dec[2];
  assign w_in_div  = w_dec[1];
  assign w_in_long = w_in_mul | w_in_div;
  assign w_s1      = w_dec[0] & mdu.src1_i[WIDTH-1];
  assign w_s2      = w_dec[0] & mdu.src2_i[WIDTH-1];
  assign w_abs1    = w_s1 ? -mdu.src1_i : mdu.src1_i;
  assign w_abs2    = w_s2 ? -mdu.src2_i : mdu.src2_i;

  // One CALC cycle: STEP unrolled shift-add or restoring shift-subtract steps.
  // The working pair holds {partial product, multiplier} or {remainder, quotient}.
  logic [WIDTH-1:0] w_nxt_hi;
  logic [WIDTH-1:0] w_nxt_lo;
  logic [WIDTH:0]   w_t;
  logic             w_qbit;

  always_comb begin
    w_nxt_hi = r_acc_hi;
    w_nxt_lo = r_acc_lo;
    w_t      = '0;
    w_qbit   = 1'b0;
    for (int k = 0; k < STEP; k++) begin
      if (r_is_div) begin
        w_t      = {w_nxt_hi, w_nxt_lo[WIDTH-1]};
        w_qbit   = (w_t >= {1'b0, r_opnd});
        if (w_qbit)
          w_t = w_t - {1'b0, r_opnd};
        w_nxt_hi = w_t[WIDTH-1:0];
        w_nxt_lo = {w_nxt_lo[WIDTH-2:0], w_qbit};
      end else begin
        w_t      = {1'b0, w_nxt_hi} + {1'b0, r_opnd & {WIDTH{w_nxt_lo[0]}}};
        w_nxt_hi = w_t[WIDTH:1];
        w_nxt_lo = {w_t[0], w_nxt_lo[WIDTH-1:1]};
      end
    end
  end

  logic [2*WIDTH-1:0] w_prod_mag;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_prod_mag = {r_acc_hi, r_acc_lo};
  assign w_prod     = r_neg_q ? -w_prod_mag : w_prod_mag;
  assign w_quo      = r_neg_q ? -r_acc_lo : r_acc_lo;
  assign w_rem      = r_neg_r ? -r_acc_hi : r_acc_hi;

`ifdef MDU_ACC_EN
  logic [2*WIDTH-1:0] w_acc_res;
  assign w_acc_res = r_sub ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);
`endif

  // Divide-by-zero forces LO to all ones; HI already rebuilds src1 from |src1| and sign.
  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      w_res_hi = w_rem;
      w_res_lo = r_div0 ? {WIDTH{1'b1}} : w_quo;
    end
`ifdef MDU_ACC_EN
    else if (r_acc) begin
      w_res_hi = w_acc_res[2*WIDTH-1:WIDTH];
      w_res_lo = w_acc_res[WIDTH-1:0];
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_opnd   <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
`ifdef MDU_ACC_EN
      r_acc    <= 1'b0;
      r_sub    <= 1'b0;
`endif
    end else if (mdu.annul_i) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mdu.start_i && w_in_long) begin
            r_state  <= S_CALC;
            r_cnt    <= '0;
            r_opnd   <= w_in_div ? w_abs2 : w_abs1;
            r_acc_lo <= w_in_div ? w_abs1 : w_abs2;
            r_acc_hi <= '0;
            r_is_div <= w_in_div;
            r_neg_q  <= w_s1 ^ w_s2;
            r_neg_r  <= w_s1;
            r_div0   <= w_in_div && (mdu.src2_i == '0);
`ifdef MDU_ACC_EN
            r_acc    <= (mdu.op_i == OP_MADD) || (mdu.op_i == OP_MADDU) ||
                        (mdu.op_i == OP_MSUB) || (mdu.op_i == OP_MSUBU);
            r_sub    <= (mdu.op_i == OP_MSUB) || (mdu.op_i == OP_MSUBU);
`endif
          end
        end
        S_CALC: begin
          r_acc_hi <= w_nxt_hi;
          r_acc_lo <= w_nxt_lo;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == C_CNT_LAST)
            r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (!mdu.annul_i) begin
      if (r_state == S_DONE) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if ((r_state == S_IDLE) && mdu.start_i) begin
        if (mdu.op_i == OP_MTHI)
          r_hi <= mdu.src1_i;
        if (mdu.op_i == OP_MTLO)
          r_lo <= mdu.src1_i;
      end
    end
  end

  logic w_stall;
  always_comb begin
    w_stall = 1'b0;
    if (!mdu.annul_i) begin
      case (r_state)
        S_IDLE:  w_stall = mdu.start_i & w_in_long;
        S_CALC:  w_stall = 1'b1;
        default: w_stall = 1'b0;
      endcase
    end
  end

  assign mdu.stallreq_o = w_stall;
  assign mdu.busy_o     = (r_state == S_CALC);
  assign mdu.done_o     = (r_state == S_DONE);
  assign mdu.hi_o       = r_hi;
  assign mdu.lo_o       = r_lo;

endmodule
`default_nettype wire
